// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 3-to-8 decoder select path.
// A grant is held while its request stays up, and is preempted after MAX_HOLD cycles if others wait.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [7:0] gnt_q, gnt_d;

    // Circular search for the first set bit at or after start; result is {found, index}.
    function automatic logic [3:0] scan(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] k;
        found = 1'b0;
        idx   = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            k = start + i[2:0];
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    logic [3:0] scan_ptr;
    logic [3:0] scan_next;
    logic       holder_req;
    logic       others_req;

    always_comb begin
        scan_ptr   = scan(req, ptr_q);
        scan_next  = scan(req, gnt_idx_q + 3'd1);
        holder_req = req[gnt_idx_q];
        others_req = (req & ~(8'd1 << gnt_idx_q)) != 8'd0;

        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        if (!en) begin
            state_d     = ST_IDLE;
            hold_cnt_d  = 4'd0;
            gnt_idx_d   = 3'd0;
            gnt_valid_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            hold_cnt_d  = 4'd0;
            gnt_idx_d   = scan_ptr[3] ? scan_ptr[2:0] : 3'd0;
            gnt_valid_d = scan_ptr[3];
            state_d     = scan_ptr[3] ? ST_GRANT : ST_IDLE;
        end else if (!holder_req || (hold_cnt_q == HOLD_LAST && others_req)) begin
            // Release and preemption share the rescan from c+1; preemption always finds another bit.
            ptr_d       = gnt_idx_q + 3'd1;
            hold_cnt_d  = 4'd0;
            gnt_idx_d   = scan_next[3] ? scan_next[2:0] : 3'd0;
            gnt_valid_d = scan_next[3];
            state_d     = scan_next[3] ? ST_GRANT : ST_IDLE;
        end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end

        gnt_d = gnt_valid_d ? (8'd1 << gnt_idx_d) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 4'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            gnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with a decoder fed by gnt_idx/gnt_valid.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] dec_out;

    int total = 0;
    int bad   = 0;

    decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // 3-to-8 decoder: B = gnt_idx, E = gnt_valid.
    always_comb begin
        dec_out = 8'd0;
        if (gnt_valid) dec_out[gnt_idx] = 1'b1;
    end

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp_i < 0 means no grant expected.
    task automatic chk_g(input string tag, input int exp_i);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = 8'd0;
        ei = 3'd0;
        if (exp_i >= 0) begin
            ei = exp_i[2:0];
            eg = 8'd1 << ei;
        end
        chk({tag, ".gnt"}, {24'd0, gnt}, {24'd0, eg});
        chk({tag, ".idx"}, {29'd0, gnt_idx}, {29'd0, ei});
        chk({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, exp_i >= 0});
    endtask

    initial begin
        bit prev_en;

        // Reset and basic grant
        rst_n = 1'b0; en = 1'b1; req = 8'h04;
        step(); chk_g("rst0", -1);
        step(); chk_g("rst1", -1);
        rst_n = 1'b1;
        step(); chk_g("basic", 2);

        // Round-robin fairness with two requesters
        rst_n = 1'b0; req = 8'h81;
        step(); chk_g("fair_rst", -1);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            chk_g($sformatf("fair%0d", c), ((c / 4) % 2 == 0) ? 0 : 7);
        end

        // Release and wrap-around
        rst_n = 1'b0; req = 8'h00;
        step(); rst_n = 1'b1;
        req = 8'h40; step(); chk_g("wrap_g6", 6);
        req = 8'h43; step(); chk_g("wrap_hold6", 6);
        req = 8'h03; step(); chk_g("wrap_to0", 0);
        req = 8'h02; step(); chk_g("wrap_to1", 1);
        chk("wrap_ptr", {29'd0, dut.ptr_q}, 32'd1);

        // Lone holder never preempted
        rst_n = 1'b0; req = 8'h00;
        step(); rst_n = 1'b1;
        req = 8'h10;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("lone%0d", c), {24'd0, gnt}, 32'h10);
        end
        chk("lone_hold_sat", {28'd0, dut.hold_cnt_q}, 32'd3);

        // Enable drop keeps ptr
        rst_n = 1'b0; req = 8'h00;
        step(); rst_n = 1'b1;
        req = 8'h08; step(); chk_g("en_g3a", 3);
        req = 8'h00; step(); chk_g("en_rel3", -1);
        req = 8'h08; step(); chk_g("en_g3b", 3);
        en = 1'b0;   step(); chk_g("en_off", -1);
        en = 1'b1; req = 8'h18; step(); chk_g("en_resume4", 4);

        // Mid-grant reset restores ptr=0
        req = 8'h08; step(); chk_g("mr_g3", 3);
        rst_n = 1'b0; req = 8'h18; step(); chk_g("mr_rst", -1);
        rst_n = 1'b1; step(); chk_g("mr_after", 3);

        // Random traffic: decoder consistency and enable gating
        prev_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            en  = ($urandom_range(0, 9) != 0);
            req = 8'($urandom);
            prev_en = en;
            step();
            chk("rnd_dec", {24'd0, dec_out}, {24'd0, gnt});
            chk("rnd_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
            if (!prev_en) chk("rnd_en_off", {24'd0, gnt}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares one 3-to-8 decoder select path among eight requesters. Each cycle it picks at most one requester, holds the grant while that requester keeps its request up, and preempts the holder after a bounded number of cycles when others are waiting. Its `gnt_idx`/`gnt_valid` outputs drive a decoder's select (`B`) and enable (`E`) inputs directly. `gnt` is the registered one-hot copy of that decoder output.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one requester while any other request is pending. Legal range is 1..15.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `en` input 1: arbiter enable. When low, no grant is issued.
- `req` input 8: request vector; bit i is requester i.
- `gnt` output 8: registered one-hot grant, or all zeros.
- `gnt_idx` output 3: registered index of the granted requester.
- `gnt_valid` output 1: registered flag, high when a grant is active.

## Operation
- Reset values (`rst_n`=0 at an edge):
  - `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_valid`=0.
  - State is IDLE, `ptr`=3'd0, `hold_cnt`=0.
- Reset applied mid-grant clears everything above at that edge, with no exceptions.
- Internal state:
  - FSM state: IDLE or GRANT.
  - `ptr`: 3-bit highest-priority index.
  - `hold_cnt`: 4-bit counter, saturating at `MAX_HOLD`-1.
- Output invariant: `gnt` == (`gnt_valid` ? 1<<`gnt_idx` : 0) at all times.
- Winner search: circular scan of `req` starting at `ptr`, then `ptr`+1, and so on, wrapping 7->0. The first set bit wins.
- IDLE:
  - `en`=1 and `req`!=0: load the winner into `gnt_idx`, set `gnt_valid`=1, clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, with current holder c:
  - Release: `req`[c]=0. Rescan with `ptr`=c+1 (mod 8).
    - If a winner exists, move the grant to it at the same edge; there is no idle cycle.
    - If none, go to IDLE and clear the outputs.
  - Preempt: `req`[c]=1, `hold_cnt`==`MAX_HOLD`-1, and some other `req` bit is set. Rescan from c+1; the winner is never c, because another bit is set. Move the grant and clear `hold_cnt`.
  - Hold: otherwise keep c.
    - Increment `hold_cnt`, saturating at `MAX_HOLD`-1.
    - A lone requester holds indefinitely.
- `ptr` update: set to c+1 whenever a grant to c ends, by release or preemption. `ptr` is unchanged while c holds.
- `en`=0 in any state: at the next edge go to IDLE, clear the outputs and `hold_cnt`, and keep `ptr`.
  - `en` takes precedence over release and preempt evaluation.
  - When `en` returns to 1, arbitration resumes from the retained `ptr`.
- With `MAX_HOLD`=1, any pending competitor causes rotation every cycle.

## Timing
- Grant latency is one cycle: a `req`/`en` change sampled at edge k is reflected on the outputs after edge k.
- Handover between requesters takes zero bubble cycles.
- A holder dropping its request loses the grant after the next edge, so at most one cycle of stale grant is visible.
- Requests are level-sensitive. A pulse that is not sampled at an edge is ignored. Requesters keep `req` high until they see their `gnt` bit.
- Simultaneous release by c and new requests: the new winner is chosen from the current `req` at that edge.

## Test plan
- Reset and basic grant:
  - Stimulus: hold `rst_n`=0 for 2 edges, release, set `en`=1, `req`=8'h04.
  - Required: outputs all zero during reset; after the next edge `gnt`=8'h04, `gnt_idx`=2, `gnt_valid`=1.
- Round-robin fairness:
  - Stimulus: `MAX_HOLD`=4, `req`=8'h81 held constant from reset.
  - Required: requester 0 for 4 cycles, then 7 for 4 cycles, then 0 for 4 cycles, repeating.
  - Required: the `gnt` sequence is 8'h01 x4, 8'h80 x4, with no cycle where `gnt`=0.
- Release and wrap-around:
  - Stimulus: grant held by 6, `ptr` behaviour exercised with `req`=8'h43; then drop bit 6.
  - Required: next grant is 0 (scan from 7 wraps to 0), then 1 after 0 releases.
- Lone holder never preempted:
  - Stimulus: `req`=8'h10 for 20 cycles.
  - Required: `gnt`=8'h10 every cycle after the first edge; `hold_cnt` saturates at 3.
- Enable and mid-operation reset:
  - Stimulus: holder 3; drive `en`=0 for one edge, then `en`=1 with `req`=8'h18.
  - Required: outputs zero for that cycle, then grant goes to 4 (`ptr`=4).
  - Stimulus: repeat, but pull `rst_n` low mid-grant.
  - Required: outputs zero at that edge; after release of reset, grant goes to 3 (`ptr`=0).
- Decoder consistency:
  - Stimulus: random `req`/`en` for 1000 cycles, with a decoder instance fed by `gnt_idx`/`gnt_valid`.
  - Required: decoder output == `gnt` every cycle, and `gnt` is always one-hot or zero.
